// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point round/normalise datapath.
// Flag bit positions used by the sticky flags vector {overflow, underflow,
// inexact}, and a packed rounded-result record at the default bfloat16-like
// widths (8-bit exponent, 7-bit stored fraction).
package fpu_pkg;

  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 7;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp_res_t;

endpackage

// File: rtl/fp_rne_round.sv
// Combinational round-to-nearest-even plus exception resolution.
// Ports:
//   sign, exp, frac_gs {fraction, guard, sticky}, ovf, zero : product fields
//   res_sign, res_exp, res_frac : rounded result
//   inexact : per-result inexact indication
//   events  : {overflow, underflow, inexact} events for the sticky flags
module fp_rne_round
  import fpu_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7
) (
  input  logic                  sign,
  input  logic [EXP_WIDTH-1:0]  exp,
  input  logic [FRAC_WIDTH+1:0] frac_gs,
  input  logic                  ovf,
  input  logic                  zero,
  output logic                  res_sign,
  output logic [EXP_WIDTH-1:0]  res_exp,
  output logic [FRAC_WIDTH-1:0] res_frac,
  output logic                  inexact,
  output logic [2:0]            events
);

  localparam logic [EXP_WIDTH:0] EXP_INF = {1'b0, {EXP_WIDTH{1'b1}}};

  // Nearest-even: round up above half, or at exactly half when the LSB is odd.
  function automatic logic rne_inc(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

  logic [FRAC_WIDTH-1:0] frac;
  logic                  guard;
  logic                  sticky;
  logic [FRAC_WIDTH:0]   frac_sum;
  logic [EXP_WIDTH:0]    exp_sum;

  assign frac   = frac_gs[FRAC_WIDTH+1:2];
  assign guard  = frac_gs[1];
  assign sticky = frac_gs[0];

  // A carry out of the fraction leaves all-zero low bits and bumps the exponent.
  assign frac_sum = {1'b0, frac} + {{FRAC_WIDTH{1'b0}}, rne_inc(frac[0], guard, sticky)};
  assign exp_sum  = {1'b0, exp} + {{EXP_WIDTH{1'b0}}, frac_sum[FRAC_WIDTH]};

  always_comb begin
    res_sign = sign;
    res_exp  = '0;
    res_frac = '0;
    inexact  = 1'b0;
    events   = '0;
    if (zero) begin
      // Exact signed zero; dominates any upstream overflow indication.
      res_exp = '0;
    end else if (ovf || (exp_sum >= EXP_INF)) begin
      res_exp          = '1;
      inexact          = 1'b1;
      events[FLAG_OVF] = 1'b1;
    end else if (exp == '0) begin
      // Denormals are not supported: flush to signed zero.
      inexact          = 1'b1;
      events[FLAG_UNF] = 1'b1;
    end else begin
      res_exp          = exp_sum[EXP_WIDTH-1:0];
      res_frac         = frac_sum[FRAC_WIDTH-1:0];
      inexact          = guard | sticky;
      events[FLAG_INX] = guard | sticky;
    end
  end

endmodule

// File: rtl/fp_round_norm.sv
// Two-stage rounding/normalisation stage for a floating-point multiplier.
// S1 registers accepted product fields; S2 holds the rounded result.
// Valid/ready handshake on both sides, full throughput when out_ready is high.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready             : upstream handshake
//   in_sign, in_exp, in_frac      : product, in_frac = {fraction, guard, sticky}
//   in_ovf, in_zero               : upstream exception indications
//   out_valid/out_ready           : downstream handshake
//   out_sign, out_exp, out_frac   : rounded result
//   out_inexact                   : per-result inexact
//   flag_clr, flags               : sticky {overflow, underflow, inexact}
module fp_round_norm #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_WIDTH-1:0]  in_exp,
  input  logic [FRAC_WIDTH+1:0] in_frac,
  input  logic                  in_ovf,
  input  logic                  in_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [EXP_WIDTH-1:0]  out_exp,
  output logic [FRAC_WIDTH-1:0] out_frac,
  output logic                  out_inexact,
  input  logic                  flag_clr,
  output logic [2:0]            flags
);

  logic                  vld_p1, sign_p1, ovf_p1, zero_p1;
  logic [EXP_WIDTH-1:0]  exp_p1;
  logic [FRAC_WIDTH+1:0] frac_p1;

  logic                  vld_p2, sign_p2, inx_p2;
  logic [EXP_WIDTH-1:0]  exp_p2;
  logic [FRAC_WIDTH-1:0] frac_p2;
  logic [2:0]            flags_q;

  logic                  load_p1, load_p2, accept;
  logic                  rnd_sign, rnd_inx;
  logic [EXP_WIDTH-1:0]  rnd_exp;
  logic [FRAC_WIDTH-1:0] rnd_frac;
  logic [2:0]            rnd_events, flag_set;

  assign load_p2  = !vld_p2 | out_ready;
  assign load_p1  = !vld_p1 | load_p2;
  assign in_ready = load_p1;
  assign accept   = in_valid & load_p1;

  // ---- S1: capture accepted product fields ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      sign_p1 <= 1'b0;
      exp_p1  <= '0;
      frac_p1 <= '0;
      ovf_p1  <= 1'b0;
      zero_p1 <= 1'b0;
    end else begin
      if (load_p1) vld_p1 <= in_valid;
      if (accept) begin
        sign_p1 <= in_sign;
        exp_p1  <= in_exp;
        frac_p1 <= in_frac;
        ovf_p1  <= in_ovf;
        zero_p1 <= in_zero;
      end
    end
  end

  fp_rne_round #(
    .EXP_WIDTH  (EXP_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_round (
    .sign     (sign_p1),
    .exp      (exp_p1),
    .frac_gs  (frac_p1),
    .ovf      (ovf_p1),
    .zero     (zero_p1),
    .res_sign (rnd_sign),
    .res_exp  (rnd_exp),
    .res_frac (rnd_frac),
    .inexact  (rnd_inx),
    .events   (rnd_events)
  );

  // Events are recorded exactly once, on the cycle a result moves into S2.
  assign flag_set = (load_p2 && vld_p1) ? rnd_events : 3'b000;

  // ---- S2: rounded result and sticky flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      sign_p2 <= 1'b0;
      exp_p2  <= '0;
      frac_p2 <= '0;
      inx_p2  <= 1'b0;
      flags_q <= 3'b000;
    end else begin
      if (load_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          sign_p2 <= rnd_sign;
          exp_p2  <= rnd_exp;
          frac_p2 <= rnd_frac;
          inx_p2  <= rnd_inx;
        end
      end
      // A clear coinciding with a new event still leaves that event set.
      flags_q <= (flag_clr ? 3'b000 : flags_q) | flag_set;
    end
  end

  assign out_valid   = vld_p2;
  assign out_sign    = sign_p2;
  assign out_exp     = exp_p2;
  assign out_frac    = frac_p2;
  assign out_inexact = inx_p2;
  assign flags       = flags_q;

endmodule
